seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, handshaked successor of the team's 4-bit combinational ALU: WIDTH-bit operands, the same 8 opcodes, registered results.
- Single-cycle ops (ADD/SUB/logic) complete in one cycle.
- MUL and DIV run on an iterative shift-add / restoring engine taking WIDTH cycles.
- Sits between the operand-capture logic and the result mux of the top-level tile; valid/ready on both sides allows back-pressure.

Parameters:
WIDTH, 8, operand width in bits (legal 4..16)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/opcode presented
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand a
b  input  WIDTH  operand b
opcode  input  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT (~a)
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  result; DIV packs {remainder, quotient}, remainder in upper half
carry_out  output  1  ADD carry; SUB no-borrow (1 when a>=b unsigned)
overflow  output  1  two's-complement overflow for ADD/SUB
div_by_zero  output  1  DIV with b==0

Behaviour:
- Clock, reset, interface:
  - One clock (clk).
  - rst is asynchronous and active-high.
  - Reset values: all outputs 0 except in_ready=1 (state IDLE). result=0, out_valid=0, flags=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0, iteration counter active.
  - DONE: in_ready=0, out_valid=1.
- Accept: an operation is accepted on a rising edge with in_valid && in_ready. a, b and opcode are captured internally; later input changes have no effect.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT, and DIV with b==0):
  - IDLE -> DONE on the accept edge.
  - out_valid is high the cycle after accept (latency 1).
- MUL and DIV with b!=0:
  - IDLE -> BUSY on the accept edge.
  - Counter loads WIDTH-1 and decrements once per cycle.
  - BUSY -> DONE on the edge where counter==0; out_valid rises WIDTH+1 edges after accept.
- DONE -> IDLE on the edge with out_ready=1. Outputs hold stable while out_ready=0, for any duration.
- No accept in the cycle DONE is left: in_ready rises the cycle after the result handshake.
- Arithmetic and widths:
  - ADD/SUB: WIDTH-bit result zero-extended to 2*WIDTH.
  - Logic ops: WIDTH-bit result, upper half 0.
  - MUL: full 2*WIDTH unsigned product.
  - DIV: unsigned.
- Flags:
  - carry_out and overflow are meaningful only for ADD/SUB and are 0 for all other ops. Flags are never held over from a prior op.
  - ADD overflow = operands share a sign bit and the sum sign differs.
  - SUB overflow = operand sign bits differ and the difference sign differs from a.
- Divide by zero: quotient=0, remainder=a, div_by_zero=1, latency 1. div_by_zero is 0 for every other op/case.
- Illegal or X opcode: not possible (all 8 codes are defined).
- Reset mid-operation: rst in BUSY or DONE aborts immediately to IDLE with reset output values. The partial result is discarded and no out_valid pulse follows.

Optional Feature:
SEQ_ALU_ZN_FLAGS_EN
- Defined: adds two output ports, zero_flag (result==0) and neg_flag (MSB of the WIDTH-bit result for ADD/SUB/logic, MSB of the 2*WIDTH result for MUL, 0 for DIV).
  - Both are registered with result, reset to 0 and held in DONE.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode enum (OP_ADD..OP_NOT);
  - FSM state enum (ST_IDLE, ST_BUSY, ST_DONE);
  - localparam helper for the counter width, $clog2(WIDTH).
- One sub-module, seq_alu_muldiv: the iterative engine holding accumulator, shift registers and counter.
  - Interface: start, is_div, a, b, done, product, quotient, remainder.
- Top level holds the FSM, single-cycle datapath, flag logic and output registers.

Test Plan:
All scenarios use WIDTH=8 unless stated.
1. ADD a=200, b=100, out_ready=1 -> out_valid one cycle after accept; result=0x002C, carry_out=1, overflow=0. Then ADD 100+100 -> 0x00C8, carry_out=0, overflow=1.
2. SUB a=5, b=7 -> result=0x00FE, carry_out=0, overflow=0. NOT a=0x0F -> 0x00F0, flags 0.
3. MUL a=15, b=17 -> out_valid exactly 9 edges after accept, result=0x00FF. MUL 255*255 -> 0xFE01.
4. DIV a=100, b=7 -> 9-edge latency, result=0x020E, div_by_zero=0. DIV a=0x5A, b=0 -> latency 1, result=0x5A00, div_by_zero=1.
5. Back-pressure: out_ready=0 for 3 cycles after out_valid -> result/flags stable and in_ready=0 throughout. in_ready=1 the cycle after the handshake. A new in_valid held during the stall is accepted only then.
6. Assert rst for 1 cycle at BUSY cycle 4 of a MUL -> immediately in_ready=1, out_valid=0, result=0. The next ADD 1+1 -> 0x0002. Repeat with WIDTH=4 and SEQ_ALU_ZN_FLAGS_EN defined: SUB 3-3 -> zero_flag=1, neg_flag=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the
// iteration-counter width helper.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NOT = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold WIDTH-1; $clog2(WIDTH) suffices for the legal 4..16 range.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, WIDTH
// iterations. Results are presented combinationally in the cycle done is high.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  localparam int CW = cnt_width(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   qreg_q, qreg_d, b_q, rem_sub;
  logic [WIDTH:0]     shrem;
  logic [CW-1:0]      cnt_q;
  logic               run_q, div_q;

  // qreg holds the multiplier (shifted right) or the dividend/quotient (shifted left).
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    qreg_d  = qreg_q;
    shrem   = {acc_q[WIDTH-1:0], qreg_q[WIDTH-1]};
    rem_sub = shrem[WIDTH-1:0] - b_q;
    if (div_q) begin
      if (shrem >= {1'b0, b_q}) begin
        acc_d  = {{WIDTH{1'b0}}, rem_sub};
        qreg_d = {qreg_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d  = {{WIDTH{1'b0}}, shrem[WIDTH-1:0]};
        qreg_d = {qreg_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (qreg_q[0]) acc_d = acc_q + mcand_q;
      mcand_d = mcand_q << 1;
      qreg_d  = qreg_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      qreg_q  <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      div_q   <= 1'b0;
    end else if (start) begin
      acc_q   <= '0;
      mcand_q <= {{WIDTH{1'b0}}, a};
      qreg_q  <= is_div ? a : b;
      b_q     <= b;
      div_q   <= is_div;
      cnt_q   <= CW'(WIDTH - 1);
      run_q   <= 1'b1;
    end else if (run_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      qreg_q  <= qreg_d;
      cnt_q   <= cnt_q - 1'b1;
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

  assign done      = run_q && (cnt_q == '0);
  assign product   = acc_d;
  assign quotient  = qreg_d;
  assign remainder = acc_d[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU with registered results; MUL/DIV use the iterative engine.
// Optional zero/negative flag outputs are enabled by SEQ_ALU_ZN_FLAGS_EN.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               overflow,
  output logic               div_by_zero
`ifdef SEQ_ALU_ZN_FLAGS_EN
  ,
  output logic               zero_flag,
  output logic               neg_flag
`endif
);

  state_e             state_q, state_d;
  opcode_e            op;
  logic               accept, is_iter, eng_start, load_sc, load_eng;
  logic               is_div_q, eng_done;
  logic [2*WIDTH-1:0] eng_prod, eng_res, sc_res;
  logic [WIDTH-1:0]   eng_quo, eng_rem;
  logic [WIDTH:0]     sum, diff;
  logic               sc_carry, sc_ovf, sc_dbz;

  assign op        = opcode_e'(opcode);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign is_iter   = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dbz   = 1'b0;
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    case (op)
      OP_ADD: begin
        sc_res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        sc_carry = ~diff[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // Only reached with b==0; nonzero divisors go to the engine.
      OP_DIV: begin
        sc_res = {a, {WIDTH{1'b0}}};
        sc_dbz = 1'b1;
      end
      OP_AND:  sc_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:   sc_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR:  sc_res = {{WIDTH{1'b0}}, a ^ b};
      OP_NOT:  sc_res = {{WIDTH{1'b0}}, ~a};
      default: sc_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    eng_start = 1'b0;
    load_sc   = 1'b0;
    load_eng  = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (is_iter) begin
          eng_start = 1'b1;
          state_d   = ST_BUSY;
        end else begin
          load_sc = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_BUSY: if (eng_done) begin
        load_eng = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .is_div    (op == OP_DIV),
    .a         (a),
    .b         (b),
    .done      (eng_done),
    .product   (eng_prod),
    .quotient  (eng_quo),
    .remainder (eng_rem)
  );

  assign eng_res = is_div_q ? {eng_rem, eng_quo} : eng_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      is_div_q    <= 1'b0;
    end else begin
      if (eng_start) is_div_q <= (op == OP_DIV);
      if (load_sc) begin
        result      <= sc_res;
        carry_out   <= sc_carry;
        overflow    <= sc_ovf;
        div_by_zero <= sc_dbz;
      end else if (load_eng) begin
        result      <= eng_res;
        carry_out   <= 1'b0;
        overflow    <= 1'b0;
        div_by_zero <= 1'b0;
      end
    end
  end

`ifdef SEQ_ALU_ZN_FLAGS_EN
  // Single-cycle results keep the upper half clear, so bit WIDTH-1 is their sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else if (load_sc) begin
      zero_flag <= (sc_res == '0);
      neg_flag  <= sc_res[WIDTH-1];
    end else if (load_eng) begin
      zero_flag <= (eng_res == '0);
      neg_flag  <= is_div_q ? 1'b0 : eng_prod[2*WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8 main instance, WIDTH=4 side instance).
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [2:0]  opcode;
  logic [15:0] result;
  logic        carry_out, overflow, div_by_zero;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [3:0]  s_a, s_b;
  logic [2:0]  s_opcode;
  logic [7:0]  s_result;
  logic        s_carry_out, s_overflow, s_div_by_zero;
`ifdef SEQ_ALU_ZN_FLAGS_EN
  logic        zero_flag, neg_flag, s_zero_flag, s_neg_flag;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .div_by_zero(div_by_zero)
`ifdef SEQ_ALU_ZN_FLAGS_EN
    , .zero_flag(zero_flag), .neg_flag(neg_flag)
`endif
  );

  seq_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .opcode(s_opcode), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .result(s_result), .carry_out(s_carry_out),
    .overflow(s_overflow), .div_by_zero(s_div_by_zero)
`ifdef SEQ_ALU_ZN_FLAGS_EN
    , .zero_flag(s_zero_flag), .neg_flag(s_neg_flag)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1, measure latency (accept edge counts as 1), check outputs.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] x,
                        input logic [7:0] y, input int exp_lat, input logic [15:0] exp_res,
                        input logic ec, input logic eo, input logic ed,
                        input logic ez, input logic en);
    int lat;
    opcode = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'hA5; b = 8'h3C; opcode = 3'd6;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_carry"}, carry_out, ec);
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_dbz"}, div_by_zero, ed);
`ifdef SEQ_ALU_ZN_FLAGS_EN
    chk({tag, "_zero"}, zero_flag, ez);
    chk({tag, "_neg"}, neg_flag, en);
`else
    if (ez && en) $display("note: %s zero/neg both set in vector", tag);
`endif
    @(posedge clk); #1;
    chk({tag, "_inrdy_after"}, in_ready, 1'b1);
  endtask

  initial begin
    int seen;
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 16'h0);
    chk("rst_flags", {carry_out, overflow, div_by_zero}, 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add1", 3'd0, 8'd200, 8'd100, 1, 16'h002C, 1, 0, 0, 0, 0);
    run_op("add2", 3'd0, 8'd100, 8'd100, 1, 16'h00C8, 0, 1, 0, 0, 1);
    run_op("sub1", 3'd1, 8'd5,   8'd7,   1, 16'h00FE, 0, 0, 0, 0, 1);
    run_op("sub2", 3'd1, 8'h80,  8'h01,  1, 16'h007F, 1, 1, 0, 0, 0);
    run_op("not1", 3'd7, 8'h0F,  8'h00,  1, 16'h00F0, 0, 0, 0, 0, 1);
    run_op("and1", 3'd4, 8'hF0,  8'h3C,  1, 16'h0030, 0, 0, 0, 0, 0);
    run_op("or1",  3'd5, 8'hF0,  8'h3C,  1, 16'h00FC, 0, 0, 0, 0, 1);
    run_op("mul1", 3'd2, 8'd15,  8'd17,  9, 16'h00FF, 0, 0, 0, 0, 0);
    run_op("mul2", 3'd2, 8'd255, 8'd255, 9, 16'hFE01, 0, 0, 0, 0, 1);
    run_op("mul0", 3'd2, 8'd0,   8'd9,   9, 16'h0000, 0, 0, 0, 1, 0);
    run_op("div1", 3'd3, 8'd100, 8'd7,   9, 16'h020E, 0, 0, 0, 0, 0);
    run_op("div2", 3'd3, 8'd255, 8'd16,  9, 16'h0F0F, 0, 0, 0, 0, 0);
    run_op("div0", 3'd3, 8'h5A,  8'd0,   1, 16'h5A00, 0, 0, 1, 0, 0);
    run_op("add3", 3'd0, 8'd1,   8'd1,   1, 16'h0002, 0, 0, 0, 0, 0);

    // Back-pressure with a second request waiting.
    out_ready = 1'b0; opcode = 3'd0; a = 8'd3; b = 8'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid0", out_valid, 1'b1);
    opcode = 3'd6; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_res", result, 16'h0007);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_inrdy", in_ready, 1'b0);
      chk("bp_flags", {carry_out, overflow, div_by_zero}, 3'b000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_inrdy_rise", in_ready, 1'b1);
    chk("bp_valid_drop", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_xor_valid", out_valid, 1'b1);
    chk("bp_xor_res", result, 16'h00CC);
    @(posedge clk); #1;
    chk("bp_inrdy_end", in_ready, 1'b1);

    // Reset in the middle of a multiply.
    opcode = 3'd2; a = 8'd15; b = 8'd17; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_busy", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid_inrdy", in_ready, 1'b1);
    chk("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_res", result, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rstmid_no_valid", seen, 0);
    run_op("add_post", 3'd0, 8'd1, 8'd1, 1, 16'h0002, 0, 0, 0, 0, 0);

    // WIDTH=4 instance.
    s_opcode = 3'd1; s_a = 4'd3; s_b = 4'd3; s_in_valid = 1'b1; s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    chk("w4_sub_valid", s_out_valid, 1'b1);
    chk("w4_sub_res", s_result, 8'h00);
    chk("w4_sub_flags", {s_carry_out, s_overflow, s_div_by_zero}, 3'b100);
`ifdef SEQ_ALU_ZN_FLAGS_EN
    chk("w4_sub_zero", s_zero_flag, 1'b1);
    chk("w4_sub_neg", s_neg_flag, 1'b0);
`endif
    @(posedge clk); #1;
    s_opcode = 3'd2; s_a = 4'd15; s_b = 4'd15; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_a = 4'd0; s_b = 4'd0;
    lat = 1;
    while (!s_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w4_mul_lat", lat, 5);
    chk("w4_mul_res", s_result, 8'hE1);
`ifdef SEQ_ALU_ZN_FLAGS_EN
    chk("w4_mul_zero", s_zero_flag, 1'b0);
    chk("w4_mul_neg", s_neg_flag, 1'b1);
`endif
    @(posedge clk); #1;
    chk("w4_inrdy_after", s_in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
